// File: rtl/mult_share_arbiter_if.sv
// Bundles the two requester channels, the shared multiplier handshake and
// the tagged result port of mult_share_arbiter.
interface mult_share_arbiter_if #(
   parameter int DATA_W = 8
);
   logic                  req0;
   logic                  req1;
   logic [DATA_W-1:0]     a0;
   logic [DATA_W-1:0]     b0;
   logic [DATA_W-1:0]     a1;
   logic [DATA_W-1:0]     b1;
   logic                  ack0;
   logic                  ack1;
   logic                  mul_start;
   logic [DATA_W-1:0]     mul_a;
   logic [DATA_W-1:0]     mul_b;
   logic                  mul_done;
   logic [2*DATA_W-1:0]   mul_product;
   logic                  res_valid;
   logic [2*DATA_W-1:0]   res_data;
   logic                  res_id;
   logic                  err_timeout;
   logic                  busy;

   // Arbiter side: consumes requests and multiplier completion, drives the rest.
   modport master (
      input  req0, req1, a0, b0, a1, b1, mul_done, mul_product,
      output ack0, ack1, mul_start, mul_a, mul_b,
             res_valid, res_data, res_id, err_timeout, busy
   );

   // Environment side: requesters, multiplier and result consumer.
   modport slave (
      output req0, req1, a0, b0, a1, b1, mul_done, mul_product,
      input  ack0, ack1, mul_start, mul_a, mul_b,
             res_valid, res_data, res_id, err_timeout, busy
   );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one start/done multiplier between two requesters.
// A job is granted in IDLE, runs until mul_done or the watchdog expires, and
// passes through DONE so mul_start is low for at least one cycle between jobs.
module mult_share_arbiter #(
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mult_share_arbiter_if.master bus
);

   localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  gnt, gnt_nxt;
   logic                  last_grant, last_grant_nxt;
   logic [WD_W-1:0]       wd, wd_nxt;
   logic                  ack0_r, ack0_nxt;
   logic                  ack1_r, ack1_nxt;
   logic                  start_r, start_nxt;
   logic [DATA_W-1:0]     mul_a_r, mul_a_nxt;
   logic [DATA_W-1:0]     mul_b_r, mul_b_nxt;
   logic                  valid_r, valid_nxt;
   logic [2*DATA_W-1:0]   data_r, data_nxt;
   logic                  id_r, id_nxt;
   logic                  err_r, err_nxt;
   logic                  pick;

   // State and all registered outputs; reset discards any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         wd         <= '0;
         ack0_r     <= 1'b0;
         ack1_r     <= 1'b0;
         start_r    <= 1'b0;
         mul_a_r    <= '0;
         mul_b_r    <= '0;
         valid_r    <= 1'b0;
         data_r     <= '0;
         id_r       <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         last_grant <= last_grant_nxt;
         wd         <= wd_nxt;
         ack0_r     <= ack0_nxt;
         ack1_r     <= ack1_nxt;
         start_r    <= start_nxt;
         mul_a_r    <= mul_a_nxt;
         mul_b_r    <= mul_b_nxt;
         valid_r    <= valid_nxt;
         data_r     <= data_nxt;
         id_r       <= id_nxt;
         err_r      <= err_nxt;
      end
   end

   // Arbitration, multiplier sequencing and watchdog; pulses default low.
   always_comb begin
      state_nxt      = state;
      gnt_nxt        = gnt;
      last_grant_nxt = last_grant;
      wd_nxt         = wd;
      ack0_nxt       = 1'b0;
      ack1_nxt       = 1'b0;
      start_nxt      = start_r;
      mul_a_nxt      = mul_a_r;
      mul_b_nxt      = mul_b_r;
      valid_nxt      = 1'b0;
      data_nxt       = data_r;
      id_nxt         = id_r;
      err_nxt        = 1'b0;
      pick           = 1'b0;

      case (state)
         IDLE: begin
            start_nxt = 1'b0;
            if (bus.req0 || bus.req1) begin
               // A tie goes to the channel not served last time.
               pick           = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
               gnt_nxt        = pick;
               last_grant_nxt = pick;
               wd_nxt         = '0;
               start_nxt      = 1'b1;
               state_nxt      = RUN;
               if (pick) begin
                  mul_a_nxt = bus.a1;
                  mul_b_nxt = bus.b1;
                  ack1_nxt  = 1'b1;
               end else begin
                  mul_a_nxt = bus.a0;
                  mul_b_nxt = bus.b0;
                  ack0_nxt  = 1'b1;
               end
            end
         end

         RUN: begin
            wd_nxt = wd + WD_ONE;
            // Completion takes priority over a watchdog expiry in the same cycle.
            if (bus.mul_done) begin
               start_nxt = 1'b0;
               data_nxt  = bus.mul_product;
               id_nxt    = gnt;
               valid_nxt = 1'b1;
               state_nxt = DONE;
            end else if (wd == WD_LAST) begin
               start_nxt = 1'b0;
               err_nxt   = 1'b1;
               state_nxt = DONE;
            end
         end

         DONE: begin
            start_nxt = 1'b0;
            state_nxt = IDLE;
         end

         default: begin
            start_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.ack0        = ack0_r;
   assign bus.ack1        = ack1_r;
   assign bus.mul_start   = start_r;
   assign bus.mul_a       = mul_a_r;
   assign bus.mul_b       = mul_b_r;
   assign bus.res_valid   = valid_r;
   assign bus.res_data    = data_r;
   assign bus.res_id      = id_r;
   assign bus.err_timeout = err_r;
   assign bus.busy        = (state != IDLE);

endmodule
